// File: rtl/rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rr_bus_arbiter
//   Round-robin arbiter granting one shared resource to one of N requesters
//   at a time. The owner keeps the grant until it releases it, withdraws its
//   request, or has held it for MAX_HOLD cycles. Every hand-over is followed
//   by one idle turnaround cycle before the next owner is granted.
//
// Ports
//   C        in   1    clock, all state updates on posedge
//   R        in   1    asynchronous active-high reset
//   req      in   N    request vector, bit i = requester i
//   rel      in   1    release strobe from the current owner (GRANT only)
//   gnt      out  N    registered one-hot grant, all-zero when no owner
//   gnt_id   out  IW   index of current owner, holds last owner when gnt=0
//   busy     out  1    1 while an owner holds the grant (== |gnt)
//   timeout  out  1    1-cycle pulse in the turnaround cycle after a
//                      release forced purely by the hold limit
// ---------------------------------------------------------------------------
module rr_bus_arbiter #(
   parameter  int N        = 4,
   parameter  int MAX_HOLD = 8,
   localparam int IW       = $clog2(N),
   localparam int HW       = $clog2(MAX_HOLD + 1)
) (
   input  logic          C,
   input  logic          R,
   input  logic [N-1:0]  req,
   input  logic          rel,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_id,
   output logic          busy,
   output logic          timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [HW-1:0] cnt;

   logic [IW-1:0] scan_idx [N];
   logic          found;
   logic [IW-1:0] win;
   logic [N-1:0]  win_onehot;

   logic          hit_limit;
   logic          owner_req;
   logic          do_release;
   logic [IW-1:0] next_ptr;

   // Rotating priority scan: candidate k is (ptr + k) mod N, first hit wins.
   always_comb begin
      found      = 1'b0;
      win        = '0;
      win_onehot = '0;
      for (int unsigned k = 0; k < N; k++) begin
         scan_idx[k] = IW'((32'(ptr) + k) % N);
         if (!found && req[scan_idx[k]]) begin
            found = 1'b1;
            win   = scan_idx[k];
         end
      end
      win_onehot[win] = found;
   end

   always_comb begin
      hit_limit  = (cnt == HW'(MAX_HOLD - 1));
      owner_req  = req[gnt_id];
      do_release = rel || !owner_req || hit_limit;
      next_ptr   = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
   end

   always_ff @(posedge C or posedge R) begin
      if (R) begin
         state   <= S_IDLE;
         gnt     <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
         timeout <= 1'b0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            S_IDLE, S_GAP: begin
               timeout <= 1'b0;
               if (found) begin
                  state  <= S_GRANT;
                  gnt    <= win_onehot;
                  gnt_id <= win;
                  busy   <= 1'b1;
                  cnt    <= '0;
               end else begin
                  state  <= S_IDLE;
                  gnt    <= '0;
                  busy   <= 1'b0;
               end
            end
            S_GRANT: begin
               if (do_release) begin
                  state   <= S_GAP;
                  gnt     <= '0;
                  busy    <= 1'b0;
                  ptr     <= next_ptr;
                  // Timeout flags only a purely limit-forced release.
                  timeout <= hit_limit && !rel && owner_req;
               end else begin
                  cnt     <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               gnt     <= '0;
               busy    <= 1'b0;
               timeout <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_bus_arbiter
//   Directed self-checking bench for rr_bus_arbiter with N=4, MAX_HOLD=8.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   the same point, i.e. after the edge has taken effect.
// ---------------------------------------------------------------------------
module tb_rr_bus_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 8;
   localparam int IW       = 2;

   logic          C = 1'b0;
   logic          R = 1'b0;
   logic [N-1:0]  req = '0;
   logic          rel = 1'b0;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_id;
   logic          busy;
   logic          timeout;

   int pass_cnt  = 0;
   int total_cnt = 0;

   rr_bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .C       (C),
      .R       (R),
      .req     (req),
      .rel     (rel),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 C = ~C;

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   // Leaves the bench 3 units after an edge with the DUT freshly reset.
   task automatic do_reset();
      tick();
      req = '0;
      rel = 1'b0;
      R   = 1'b1;
      #2;
      R   = 1'b0;
   endtask

   task automatic test_reset();
      #2 R = 1'b1;
      #2;
      total_cnt++;
      if ({gnt, gnt_id, busy, timeout} !== 8'b0) $display("FAIL reset_init: got gnt=%b id=%0d busy=%b to=%b, want all 0", gnt, gnt_id, busy, timeout);
      else pass_cnt++;
      R = 1'b0;
      req = 4'b0100;
      tick();
      total_cnt++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2) $display("FAIL reset_pre_grant: got gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
      else pass_cnt++;
      #3 R = 1'b1;
      #1;
      total_cnt++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) $display("FAIL reset_async: got gnt=%b busy=%b id=%0d, want 0000/0/0", gnt, busy, gnt_id);
      else pass_cnt++;
      #1 R = 1'b0;
      tick();
      total_cnt++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) $display("FAIL reset_regrant: got gnt=%b id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      total_cnt++;
      if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) $display("FAIL single_grant: got gnt=%b id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
      else pass_cnt++;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      req = 4'b0000;
      total_cnt++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd2) $display("FAIL single_gap: got gnt=%b busy=%b to=%b id=%0d, want 0000/0/0/2", gnt, busy, timeout, gnt_id);
      else pass_cnt++;
      tick();
      // glitch on req and rel between edges must not be seen
      #2 req = 4'b0001; rel = 1'b1;
      #2 req = 4'b0000; rel = 1'b0;
      tick();
      total_cnt++;
      if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL single_glitch: got gnt=%b busy=%b, want 0000/0", gnt, busy);
      else pass_cnt++;
   endtask

   task automatic test_fairness();
      logic [N-1:0] exp_gnt;
      int owners [6] = '{0, 1, 2, 3, 0, 1};
      int bad = 0;
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         exp_gnt = 4'b0001 << owners[i];
         tick();
         if (gnt !== exp_gnt || gnt_id !== IW'(owners[i])) begin
            bad++;
            $display("FAIL fair_owner%0d: got gnt=%b id=%0d, want %b/%0d", i, gnt, gnt_id, exp_gnt, owners[i]);
         end
         tick();
         if (gnt !== exp_gnt) begin
            bad++;
            $display("FAIL fair_hold%0d: got gnt=%b, want %b", i, gnt, exp_gnt);
         end
         rel = 1'b1;
         tick();
         rel = 1'b0;
         if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL fair_gap%0d: got gnt=%b to=%b, want 0000/0", i, gnt, timeout);
         end
      end
      total_cnt++;
      if (bad == 0) pass_cnt++;
   endtask

   task automatic test_timeout();
      int held = 0;
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         if (gnt === 4'b0001 && timeout === 1'b0) held++;
      end
      total_cnt++;
      if (held !== MAX_HOLD) $display("FAIL timeout_hold: got %0d cycles of gnt=0001, want %0d", held, MAX_HOLD);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_gap: got gnt=%b to=%b busy=%b, want 0000/1/0", gnt, timeout, busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1 || timeout !== 1'b0) $display("FAIL timeout_next: got gnt=%b id=%0d to=%b, want 0010/1/0", gnt, gnt_id, timeout);
      else pass_cnt++;
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b1000;
      tick();
      total_cnt++;
      if (gnt !== 4'b1000 || gnt_id !== 2'd3) $display("FAIL withdraw_grant: got gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
      else pass_cnt++;
      req = 4'b1111;
      tick();
      tick();
      total_cnt++;
      if (gnt !== 4'b1000) $display("FAIL withdraw_no_preempt: got gnt=%b, want 1000", gnt);
      else pass_cnt++;
      req = 4'b0110;
      tick();
      total_cnt++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) $display("FAIL withdraw_gap: got gnt=%b to=%b, want 0000/0", gnt, timeout);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (gnt !== 4'b0010 || gnt_id !== 2'd1) $display("FAIL withdraw_next: got gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < MAX_HOLD; i++) tick();
      total_cnt++;
      if (gnt !== 4'b0001) $display("FAIL simul_last_cycle: got gnt=%b, want 0001", gnt);
      else pass_cnt++;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      total_cnt++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) $display("FAIL simul_release: got gnt=%b to=%b, want 0000/0", gnt, timeout);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) $display("FAIL simul_regrant: got gnt=%b id=%0d busy=%b, want 0001/0/1", gnt, gnt_id, busy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_withdraw();
      test_simultaneous();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
